// File: rtl/alu_result_stage.sv
// alu_result_stage: ALU result FIFO to register-file writeback plus the architectural flag register
package CPU_package;
  localparam int DATA_WIDTH = 16;
  typedef struct packed {
    logic overflow;
    logic negative;
    logic zero;
    logic carry;
  } struct_alu_flag_t;
endpackage

module alu_result_stage
  import CPU_package::*;
#(
  parameter int DATA_WIDTH = CPU_package::DATA_WIDTH,
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  struct_alu_flag_t      in_flag,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic                  in_wb_en,
  input  logic                  in_flag_we,
  input  logic                  flag_clr,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic [ADDR_WIDTH-1:0] wb_addr,
  output struct_alu_flag_t      flags_q,
  output logic                  carry_to_alu
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [0:0] EMPTY    = 1'b0;
  localparam logic [0:0] NONEMPTY = 1'b1;
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_n;
  logic [0:0] state, state_n;
  logic accept, push, pop;
  assign accept       = in_valid && in_ready;
  assign push         = accept && in_wb_en;
  assign pop          = wb_valid && wb_ready;
  assign wb_valid     = state == NONEMPTY;
  assign wb_data      = data_mem[rd_ptr];
  assign wb_addr      = addr_mem[rd_ptr];
  assign carry_to_alu = flags_q.carry;
  // next occupancy and FIFO state; no bypass, so a pop needs a pre-existing entry
  always_comb begin
    count_n = count + CW'(push) - CW'(pop);
    state_n = push ? NONEMPTY : (pop && count == CW'(1)) ? EMPTY : state;
  end
  // FIFO storage, pointers, occupancy and registered in_ready
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        addr_mem[i] <= '0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      state    <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      if (push) begin
        data_mem[wr_ptr] <= in_data;
        addr_mem[wr_ptr] <= in_addr;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count    <= count_n;
      state    <= state_n;
      in_ready <= count_n < CW'(DEPTH);
    end
  end
  // flag register: clear wins over an accepted update, loaded at accept time
  always_ff @(posedge clk) begin
    if (rst || flag_clr) flags_q <= '0;
    else if (accept && in_flag_we) flags_q <= in_flag;
  end
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: scoreboard bench with directed and random stimulus for alu_result_stage
module tb_alu_result_stage;
  import CPU_package::*;
  localparam int DW = 16, AW = 3, DEPTH = 2;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, in_wb_en = 0, in_flag_we = 0, flag_clr = 0;
  logic [DW-1:0] in_data = '0;
  logic [AW-1:0] in_addr = '0;
  struct_alu_flag_t in_flag = '0;
  logic wb_valid, wb_ready = 0, carry_to_alu;
  logic [DW-1:0] wb_data;
  logic [AW-1:0] wb_addr;
  struct_alu_flag_t flags_q;
  int checks = 0, errors = 0;
  logic [DW+AW-1:0] sbq [$];
  int mc = 0;
  logic [3:0] mflags = '0;

  alu_result_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_flag(in_flag), .in_addr(in_addr), .in_wb_en(in_wb_en), .in_flag_we(in_flag_we),
    .flag_clr(flag_clr), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_addr(wb_addr), .flags_q(flags_q), .carry_to_alu(carry_to_alu)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, a, e);
    end
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [AW-1:0] a,
                       input logic wb, input logic fw, input logic clr, input logic [3:0] f,
                       input logic rdy);
    in_valid = v; in_data = d; in_addr = a; in_wb_en = wb; in_flag_we = fw;
    flag_clr = clr; in_flag = f; wb_ready = rdy;
    @(posedge clk); #1;
  endtask

  // reference model: FIFO occupancy, expected entries and flags, advanced at each edge
  always @(posedge clk) begin
    if (rst) begin
      mc = 0; mflags = '0; sbq.delete();
    end else begin
      automatic bit acc = in_valid && (mc < DEPTH);
      automatic bit pu = acc && in_wb_en;
      automatic bit po = (mc != 0) && wb_ready;
      if (pu) sbq.push_back({in_data, in_addr});
      mc = mc + int'(pu) - int'(po);
      mflags = flag_clr ? 4'h0 : (acc && in_flag_we) ? in_flag : mflags;
    end
  end

  // monitor: compares outputs against the model and retires popped entries
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", 32'(in_ready), 32'(mc < DEPTH));
      chk("wb_valid", 32'(wb_valid), 32'(sbq.size() != 0));
      chk("flags_q", 32'(flags_q), 32'(mflags));
      chk("carry", 32'(carry_to_alu), 32'(mflags[0]));
      if (sbq.size() != 0) begin
        chk("wb_entry", 32'({wb_data, wb_addr}), 32'(sbq[0]));
        if (wb_ready) void'(sbq.pop_front());
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_data", 32'(wb_data), 32'd0);
    chk("rst_wb_addr", 32'(wb_addr), 32'd0);
    chk("rst_flags", 32'(flags_q), 32'd0);
    chk("rst_carry", 32'(carry_to_alu), 32'd0);
    drive(1, 16'h0003, 3'd2, 1, 0, 0, 4'h0, 1);
    chk("lat_valid", 32'(wb_valid), 32'd1);
    chk("lat_data", 32'(wb_data), 32'h3);
    chk("lat_addr", 32'(wb_addr), 32'd2);
    drive(0, 0, 0, 0, 0, 0, 4'h0, 1);
    chk("lat_drained", 32'(wb_valid), 32'd0);
    drive(1, 16'h0011, 3'd1, 1, 0, 0, 4'h0, 0);
    drive(1, 16'h0022, 3'd2, 1, 0, 0, 4'h0, 0);
    chk("full_ready", 32'(in_ready), 32'd0);
    drive(1, 16'h0033, 3'd3, 1, 0, 0, 4'h0, 0);
    chk("full_ignored", 32'(wb_data), 32'h11);
    drive(1, 16'h0044, 3'd4, 1, 0, 0, 4'h0, 1);
    chk("pop_ready", 32'(in_ready), 32'd1);
    chk("pop_head", 32'(wb_data), 32'h22);
    drive(1, 16'h0044, 3'd4, 1, 0, 0, 4'h0, 0);
    drive(0, 0, 0, 0, 0, 0, 4'h0, 1);
    chk("wrap_head", 32'(wb_data), 32'h44);
    drive(0, 0, 0, 0, 0, 0, 4'h0, 1);
    chk("wrap_empty", 32'(wb_valid), 32'd0);
    drive(1, 16'h0000, 3'd5, 1, 1, 0, 4'b1011, 1);
    chk("add_carry", 32'(carry_to_alu), 32'd1);
    drive(1, 16'h0001, 3'd5, 1, 0, 0, 4'b0000, 1);
    chk("carry_hold", 32'(carry_to_alu), 32'd1);
    drive(0, 0, 0, 0, 0, 1, 4'h0, 1);
    chk("carry_clr", 32'(carry_to_alu), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 4'h0, 1);
    drive(1, 16'h0000, 3'd6, 0, 1, 0, 4'b0010, 1);
    chk("cpr_flags", 32'(flags_q), 32'h2);
    chk("cpr_no_wb", 32'(wb_valid), 32'd0);
    drive(1, 16'h0000, 3'd6, 0, 1, 1, 4'b0110, 1);
    chk("cpr_clr_wins", 32'(flags_q), 32'h0);
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 3) != 0, DW'($urandom), AW'($urandom), $urandom_range(0, 4) != 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0, 4'($urandom),
            $urandom_range(0, 2) != 0);
    end
    rst = 0;
    for (int i = 0; i < 10 && mc != 0; i++) drive(0, 0, 0, 0, 0, 0, 4'h0, 1);
    chk("final_drain", 32'(mc), 32'd0);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
